// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU memory responder.
package cpu_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 2 ** AW;

  // Last loader address; reaching it ends the load.
  localparam logic [AW-1:0] LOAD_LAST = 4'd15;

  typedef enum logic [1:0] {
    SERVE   = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_core.sv
// 16x8 store: one synchronous write port, registered read port, synchronous clear.
// Ports: clk, clear (sync, wipes array and read regs), we/addr/wdata (write),
//        re (read strobe on addr), rdata/rvalid (registered read result).
module mem_core
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  // Reads see the pre-edge contents; rdata holds between reads.
  always_comb begin
    mem_d    = mem_q;
    rdata_d  = rdata_q;
    rvalid_d = re;
    if (we) mem_d[addr] = wdata;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/mem_responder.sv
// CPU RAM-port responder with a byte-stream program loader.
// Ports: clk, reset (sync, active-high); CPU side mem_addr/mem_wdata/mem_we/
//        mem_re -> mem_rdata/mem_rvalid; loader side load_start/load_data/
//        load_valid -> load_ready/load_count/load_done; CPU control
//        cpu_stop/cpu_reset.
module mem_responder
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          mem_we,
  input  logic          mem_re,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_rvalid,
  input  logic          load_start,
  input  logic [DW-1:0] load_data,
  input  logic          load_valid,
  output logic          load_ready,
  output logic [AW:0]   load_count,
  output logic          load_done,
  output logic          cpu_stop,
  output logic          cpu_reset
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          core_we;
  logic          core_re;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;

  // Next state, pointer/count and write-port mux (CPU vs loader).
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_addr  = mem_addr;
    core_wdata = mem_wdata;
    unique case (state_q)
      SERVE: begin
        core_we = mem_we;
        core_re = mem_re & ~mem_we;  // write wins; read dropped
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          core_we    = 1'b1;
          core_addr  = ptr_q;
          core_wdata = load_data;
          count_d    = (AW+1)'(count_q + 1'b1);
          // Pointer parks at the last address instead of wrapping.
          if (ptr_q == LOAD_LAST) state_d = RELEASE;
          else                    ptr_d   = AW'(ptr_q + 1'b1);
        end
      end
      RELEASE: state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SERVE;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  mem_core u_mem_core (
    .clk    (clk),
    .clear  (reset),
    .we     (core_we),
    .re     (core_re),
    .addr   (core_addr),
    .wdata  (core_wdata),
    .rdata  (mem_rdata),
    .rvalid (mem_rvalid)
  );

  // Control outputs decode the registered state only.
  assign load_ready = (state_q == LOAD);
  assign cpu_stop   = (state_q == LOAD);
  assign cpu_reset  = (state_q == LOAD) || (state_q == RELEASE);
  assign load_done  = (state_q == RELEASE);
  assign load_count = count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;
  import cpu_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          load_start;
  logic [DW-1:0] load_data;
  logic          load_valid;
  logic          load_ready;
  logic [AW:0]   load_count;
  logic          load_done;
  logic          cpu_stop;
  logic          cpu_reset;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_count (load_count),
    .load_done  (load_done),
    .cpu_stop   (cpu_stop),
    .cpu_reset  (cpu_reset)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_addr = a; mem_wdata = d; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    mem_addr = a; mem_re = 1'b1;
    tick();
    mem_re = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 16; k++) do_write(AW'(k), DW'(k + 1));
    reset = 1'b1;
    mem_re = 1'b1;
    tick();
    mem_re = 1'b0;
    tests++;
    if (mem_rdata !== 8'h00 || mem_rvalid !== 1'b0 || load_ready !== 1'b0 ||
        load_count !== 5'd0 || load_done !== 1'b0 || cpu_stop !== 1'b0 || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: rdata=%h rvalid=%b ready=%b count=%0d done=%b stop=%b creset=%b, required all zero",
               mem_rdata, mem_rvalid, load_ready, load_count, load_done, cpu_stop, cpu_reset);
    end
    reset = 1'b0;
    // Back-to-back reads of every address: rvalid stays high, data all zero.
    mem_re = 1'b1;
    for (int k = 0; k < 16; k++) begin
      mem_addr = AW'(k);
      tick();
      tests++;
      if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h00) begin
        fails++;
        $display("FAIL reset_clear[%0d]: rvalid=%b rdata=%h, required rvalid=1 rdata=00", k, mem_rvalid, mem_rdata);
      end
    end
    mem_re = 1'b0;
    tick();
    tests++;
    if (mem_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rvalid_drop: rvalid=%b, required 0", mem_rvalid);
    end
  endtask

  task automatic test_write_read();
    do_write(4'h3, 8'hA5);
    tests++;
    if (mem_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL write_no_rvalid: rvalid=%b, required 0", mem_rvalid);
    end
    do_read(4'h3);
    tests++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL write_read: rvalid=%b rdata=%h, required rvalid=1 rdata=a5", mem_rvalid, mem_rdata);
    end
    tick();
    tests++;
    if (mem_rvalid !== 1'b0 || mem_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h, required rvalid=0 rdata=a5", mem_rvalid, mem_rdata);
    end
  endtask

  task automatic test_simultaneous();
    mem_addr = 4'h7; mem_wdata = 8'h3C; mem_we = 1'b1; mem_re = 1'b1;
    tick();
    mem_we = 1'b0; mem_re = 1'b0;
    tests++;
    if (mem_rvalid !== 1'b0 || mem_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL simul_no_read: rvalid=%b rdata=%h, required rvalid=0 rdata=a5", mem_rvalid, mem_rdata);
    end
    do_read(4'h7);
    tests++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h3C) begin
      fails++;
      $display("FAIL simul_write: rvalid=%b rdata=%h, required rvalid=1 rdata=3c", mem_rvalid, mem_rdata);
    end
  endtask

  task automatic test_full_load();
    int accepted = 0;
    int dones = 0;
    bit released = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests++;
    if (cpu_stop !== 1'b1 || cpu_reset !== 1'b1 || load_ready !== 1'b1 || load_count !== 5'd0) begin
      fails++;
      $display("FAIL load_enter: stop=%b creset=%b ready=%b count=%0d, required 1 1 1 0",
               cpu_stop, cpu_reset, load_ready, load_count);
    end
    for (int c = 0; c < 64 && !released; c++) begin
      load_valid = (c % 3 != 2);      // gap every third cycle
      load_data  = DW'(8'h10 + accepted);
      load_start = (c == 4);          // must be ignored while loading
      tick();
      if (load_valid) accepted++;
      load_valid = 1'b0; load_start = 1'b0;
      if (load_done === 1'b1) dones++;
      tests++;
      if (accepted == 16) begin
        released = 1;
        if (load_done !== 1'b1 || cpu_stop !== 1'b0 || cpu_reset !== 1'b1 ||
            load_ready !== 1'b0 || load_count !== 5'd16) begin
          fails++;
          $display("FAIL release_cycle: done=%b stop=%b creset=%b ready=%b count=%0d, required 1 0 1 0 16",
                   load_done, cpu_stop, cpu_reset, load_ready, load_count);
        end
      end else if (cpu_stop !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0 ||
                   load_count !== 5'(accepted)) begin
        fails++;
        $display("FAIL load_step[%0d]: stop=%b creset=%b done=%b count=%0d, required 1 1 0 %0d",
                 c, cpu_stop, cpu_reset, load_done, load_count, accepted);
      end
    end
    tests++;
    if (!released) begin
      fails++;
      $display("FAIL load_timeout: accepted=%0d, required 16", accepted);
    end
    tick();
    if (load_done === 1'b1) dones++;
    tests++;
    if (dones != 1 || cpu_stop !== 1'b0 || cpu_reset !== 1'b0 || load_count !== 5'd16) begin
      fails++;
      $display("FAIL load_after: dones=%0d stop=%b creset=%b count=%0d, required 1 0 0 16",
               dones, cpu_stop, cpu_reset, load_count);
    end
    for (int k = 0; k < 16; k++) begin
      do_read(AW'(k));
      tests++;
      if (mem_rvalid !== 1'b1 || mem_rdata !== DW'(8'h10 + k)) begin
        fails++;
        $display("FAIL load_data[%0d]: rvalid=%b rdata=%h, required rvalid=1 rdata=%h",
                 k, mem_rvalid, mem_rdata, DW'(8'h10 + k));
      end
    end
  endtask

  task automatic test_strobes_during_load();
    int accepted = 0;
    int rv_seen = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 40 && accepted < 16; c++) begin
      load_valid = 1'b1;
      load_data  = DW'(8'h40 + accepted);
      if (c == 3) begin mem_addr = 4'h0; mem_wdata = 8'hFF; mem_we = 1'b1; end
      if (c == 6) begin mem_addr = 4'h2; mem_re = 1'b1; end
      tick();
      accepted++;
      load_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
      if (mem_rvalid === 1'b1) rv_seen++;
    end
    tests++;
    if (accepted != 16 || rv_seen != 0) begin
      fails++;
      $display("FAIL strobe_ignored: accepted=%0d rvalid_pulses=%0d, required 16 0", accepted, rv_seen);
    end
    tick();
    do_read(4'h0);
    tests++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h40) begin
      fails++;
      $display("FAIL strobe_no_write: rvalid=%b rdata=%h, required rvalid=1 rdata=40", mem_rvalid, mem_rdata);
    end
    do_read(4'h2);
    tests++;
    if (mem_rdata !== 8'h42) begin
      fails++;
      $display("FAIL strobe_load_data: rdata=%h, required 42", mem_rdata);
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = DW'(8'h60 + i);
      tick();
    end
    load_valid = 1'b0;
    tests++;
    if (load_count !== 5'd5 || cpu_stop !== 1'b1) begin
      fails++;
      $display("FAIL partial_load: count=%0d stop=%b, required 5 1", load_count, cpu_stop);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (load_count !== 5'd0 || cpu_stop !== 1'b0 || cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d stop=%b creset=%b ready=%b, required 0 0 0 0",
               load_count, cpu_stop, cpu_reset, load_ready);
    end
    mem_re = 1'b1;
    for (int k = 0; k < 16; k++) begin
      mem_addr = AW'(k);
      tick();
      tests++;
      if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h00) begin
        fails++;
        $display("FAIL mid_reset_clear[%0d]: rvalid=%b rdata=%h, required rvalid=1 rdata=00", k, mem_rvalid, mem_rdata);
      end
    end
    mem_re = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
    load_start = 1'b0; load_data = '0; load_valid = 1'b0;
    tick();
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_full_load();
    test_strobes_during_load();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
